// File: rtl/tpg_pkg.sv
// Shared definitions for the multi-mode test pattern generator.
// Holds the mode encoding, the colour fill constant and the bit-replication helper.
// Widths here are fixed at 32 bits; consumers take the top CW bits they need.
package tpg_pkg;

  typedef enum logic [2:0] {
    MODE_GRAY      = 3'd0,
    MODE_BARS      = 3'd1,
    MODE_SPECTRUM  = 3'd2,
    MODE_CHECKER   = 3'd3,
    MODE_MOVBAR    = 3'd4,
    MODE_COMPOSITE = 3'd5,
    MODE_WHITE     = 3'd6,
    MODE_BLACK     = 3'd7
  } mode_e;

  localparam logic [31:0] COLOR_ONES = '1;

  // Repeats the low k bits of value MSB-first across 32 bits. Because the fill
  // starts at the MSB, the top CW bits equal the same pattern truncated to CW.
  function automatic logic [31:0] replicate(input logic [31:0] value, input int k);
    logic [31:0] res;
    res = '0;
    for (int i = 0; i < 32; i++) begin
      res[5'(31 - i)] = value[5'(k - 1 - (i % k))];
    end
    return res;
  endfunction

endpackage

// File: rtl/tpg_coord_wrap.sv
// Combinational modular add: y = (a + b) wrapped once at HA.
// Latency: 0 (pure combinational). No flow control.
// Ports: a, b (HW bits, b < HA expected) -> y (HW bits, < HA when a < HA).
module tpg_coord_wrap #(
  parameter int HW = 10,
  parameter int HA = 640
) (
  input  logic [HW-1:0] a,
  input  logic [HW-1:0] b,
  output logic [HW-1:0] y
);

  localparam logic [HW:0] HA_X = (HW+1)'(HA);

  logic [HW:0] sum;

  // A single subtraction is enough for every in-range pixel; results for
  // blanking-interval counters may stay >= HA but are never displayed.
  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
    y   = (sum >= HA_X) ? HW'(sum - HA_X) : sum[HW-1:0];
  end

endmodule

// File: rtl/pattern_generator_multi.sv
// Multi-mode RGB test pattern source between the h/v timing counters and TMDS encoders.
// Latency: 1 clk from counters to colours/o_de/o_frame_start. No backpressure (free-running).
// Ports: clk, rst (async high), i_hcount/i_vcount, i_mode/i_anim_en/i_step (frame-latched)
//        -> o_red/o_grn/o_blu, o_de, o_frame_start, o_mode.
module pattern_generator_multi
  import tpg_pkg::*;
#(
  parameter int HMAX     = 800,
  parameter int VMAX     = 600,
  parameter int HA       = 640,
  parameter int VA       = 480,
  parameter int CW       = 8,
  parameter int CHK_LOG2 = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [$clog2(HMAX)-1:0] i_hcount,
  input  logic [$clog2(VMAX)-1:0] i_vcount,
  input  logic [2:0]              i_mode,
  input  logic                    i_anim_en,
  input  logic [3:0]              i_step,
  output logic [CW-1:0]           o_blu,
  output logic [CW-1:0]           o_grn,
  output logic [CW-1:0]           o_red,
  output logic                    o_de,
  output logic                    o_frame_start,
  output logic [2:0]              o_mode
);

  localparam int HW = $clog2(HMAX);
  localparam int VW = $clog2(VMAX);

  if (HW < CW || HW < 5 || CHK_LOG2 >= HW) begin : g_param_check
    $error("pattern_generator_multi: need HW >= CW, HW >= 5 and CHK_LOG2 < HW");
  end

  localparam logic [HW-1:0] HA_W  = HW'(HA);
  localparam logic [HW:0]   HA_X  = (HW+1)'(HA);
  localparam logic [VW-1:0] VA_W  = VW'(VA);
  localparam logic [VW-1:0] VQ_W  = VW'(VA / 4);
  localparam logic [VW-1:0] VH_W  = VW'(VA / 2);
  localparam logic [HW-1:0] BAR_W = HW'(2 ** CHK_LOG2);
  localparam logic [CW-1:0] WHITE = COLOR_ONES[CW-1:0];

  logic          en, fs;
  mode_e         mode_q, mode_eff, pat;
  logic [HW-1:0] hoff_q, hoff_nxt, hoff_eff, x, bar_end;
  logic [HW:0]   hsum;
  logic          in_bar;
  logic [31:0]   gray_full;
  logic [CW-1:0] gray_c, ramp;
  logic [CW-1:0] bars_b, bars_g, bars_r;
  logic [CW-1:0] spec_b, spec_g, spec_r;
  logic [CW-1:0] b_c, g_c, r_c;

  assign en = (i_hcount < HA_W) && (i_vcount < VA_W);
  assign fs = (i_hcount == '0) && (i_vcount == '0);

  // Offset for the upcoming frame, computed one bit wider so the wrap test is exact.
  always_comb begin
    hsum     = {1'b0, hoff_q} + (HW+1)'(i_step);
    hoff_nxt = hoff_q;
    if (i_anim_en) begin
      hoff_nxt = (hsum >= HA_X) ? HW'(hsum - HA_X) : hsum[HW-1:0];
    end
  end

  // Pixel (0,0) already renders with the settings being latched on that cycle.
  assign mode_eff = fs ? mode_e'(i_mode) : mode_q;
  assign hoff_eff = fs ? hoff_nxt : hoff_q;

  tpg_coord_wrap #(.HW(HW), .HA(HA)) u_xwrap (
    .a(i_hcount), .b(hoff_eff), .y(x)
  );

  tpg_coord_wrap #(.HW(HW), .HA(HA)) u_barwrap (
    .a(hoff_eff), .b(BAR_W), .y(bar_end)
  );

  // When bar_end has wrapped below hoff the bar straddles the right/left edges.
  assign in_bar = (bar_end > hoff_eff) ? ((i_hcount >= hoff_eff) && (i_hcount < bar_end))
                                       : ((i_hcount >= hoff_eff) || (i_hcount < bar_end));

  always_comb begin
    gray_full = replicate(32'(x[HW-2:HW-5]), 4);
    gray_c    = gray_full[31 -: CW];
    bars_b    = {x[HW-2], {(CW-1){1'b0}}};
    bars_g    = {x[HW-3], {(CW-1){1'b0}}};
    bars_r    = {x[HW-4], {(CW-1){1'b0}}};
    ramp      = x[HW-1 -: CW];
    spec_b    = WHITE;
    spec_g    = WHITE;
    spec_r    = WHITE;
    case (x[HW-1:HW-3])
      3'd0: begin spec_b = '0;    spec_g = ramp;   spec_r = WHITE; end
      3'd1: begin spec_b = '0;    spec_g = WHITE;  spec_r = ~ramp; end
      3'd2: begin spec_b = ramp;  spec_g = WHITE;  spec_r = '0;    end
      3'd3: begin spec_b = WHITE; spec_g = ~ramp;  spec_r = '0;    end
      3'd4: begin spec_b = WHITE; spec_g = '0;     spec_r = ramp;  end
      3'd5: begin spec_b = ~ramp; spec_g = '0;     spec_r = WHITE; end
      default: ;
    endcase
  end

  always_comb begin
    pat = mode_eff;
    if (mode_eff == MODE_COMPOSITE) begin
      pat = (i_vcount < VQ_W) ? MODE_GRAY : (i_vcount < VH_W) ? MODE_BARS : MODE_SPECTRUM;
    end
    b_c = '0;
    g_c = '0;
    r_c = '0;
    if (en) begin
      case (pat)
        MODE_GRAY:     begin b_c = gray_c; g_c = gray_c; r_c = gray_c; end
        MODE_BARS:     begin b_c = bars_b; g_c = bars_g; r_c = bars_r; end
        MODE_SPECTRUM: begin b_c = spec_b; g_c = spec_g; r_c = spec_r; end
        MODE_CHECKER: begin
          if (x[CHK_LOG2] ^ i_vcount[CHK_LOG2]) begin
            b_c = WHITE; g_c = WHITE; r_c = WHITE;
          end
        end
        MODE_MOVBAR: begin
          if (in_bar) begin
            b_c = WHITE; g_c = WHITE; r_c = WHITE;
          end
        end
        MODE_WHITE:    begin b_c = WHITE;  g_c = WHITE;  r_c = WHITE;  end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_blu         <= '0;
      o_grn         <= '0;
      o_red         <= '0;
      o_de          <= 1'b0;
      o_frame_start <= 1'b0;
      mode_q        <= MODE_GRAY;
      hoff_q        <= '0;
    end else begin
      o_blu         <= b_c;
      o_grn         <= g_c;
      o_red         <= r_c;
      o_de          <= en;
      o_frame_start <= fs;
      if (fs) begin
        mode_q <= mode_e'(i_mode);
        hoff_q <= hoff_nxt;
      end
    end
  end

  assign o_mode = mode_q;

  // Not every pattern consumes every coordinate or replicated bit.
  logic unused_bits;
  assign unused_bits = ^{x, gray_full};

endmodule

// File: tb/tb_pattern_generator_multi.sv
module tb_pattern_generator_multi;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] i_hcount = '0;
  logic [9:0] i_vcount = '0;
  logic [2:0] i_mode = 3'd0;
  logic       i_anim_en = 1'b0;
  logic [3:0] i_step = 4'd0;
  logic [7:0] o_blu, o_grn, o_red;
  logic       o_de, o_frame_start;
  logic [2:0] o_mode;

  int n_checks = 0;
  int n_pass   = 0;

  pattern_generator_multi dut (
    .clk(clk), .rst(rst),
    .i_hcount(i_hcount), .i_vcount(i_vcount),
    .i_mode(i_mode), .i_anim_en(i_anim_en), .i_step(i_step),
    .o_blu(o_blu), .o_grn(o_grn), .o_red(o_red),
    .o_de(o_de), .o_frame_start(o_frame_start), .o_mode(o_mode)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Present counters at negedge, let one posedge register them, sample 1 ns later.
  task automatic px(input int h, input int v);
    @(negedge clk);
    i_hcount = 10'(h);
    i_vcount = 10'(v);
    @(posedge clk);
    #1;
  endtask

  task automatic rgb(input string tag, input logic [23:0] exp);
    check(tag, {8'h0, o_red, o_grn, o_blu}, {8'h0, exp});
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    rgb("reset_rgb", 24'h000000);
    check("reset_de", o_de, 0);
    check("reset_fs", o_frame_start, 0);
    check("reset_mode", o_mode, 0);
    @(negedge clk);
    rst = 1'b0;

    // Gray: x[8:5] replicated
    px(32, 0);   rgb("gray_32", 24'h111111); check("gray_de", o_de, 1);
    check("gray_no_fs", o_frame_start, 0);
    px(639, 479); rgb("gray_639", 24'h333333); check("de_last_active", o_de, 1);
    px(640, 0);  rgb("blank_h", 24'h000000); check("de_h640", o_de, 0);
    px(10, 480); check("de_v480", o_de, 0);

    // Mode switch only at frame start
    i_mode = 3'd1;
    px(10, 100); check("mode_held", o_mode, 0);
    px(0, 0);    check("mode_new", o_mode, 1); check("fs_pulse", o_frame_start, 1);
    rgb("bars_00", 24'h000000);
    px(128, 1);  rgb("bars_128", 24'h008000);
    check("fs_drop", o_frame_start, 0);
    px(256, 1);  rgb("bars_256", 24'h000080);
    px(64, 1);   rgb("bars_64", 24'h800000);
    px(448, 1);  rgb("bars_448", 24'h808080);

    // Spectrum
    i_mode = 3'd2;
    px(0, 0);    rgb("spec_0", 24'hFF0000);
    px(128, 5);  rgb("spec_128", 24'hDFFF00);
    px(600, 5);  rgb("spec_600", 24'h9600FF);

    // Checker
    i_mode = 3'd3;
    px(0, 0);
    px(31, 0);   rgb("chk_31_0", 24'h000000);
    px(32, 0);   rgb("chk_32_0", 24'hFFFFFF);
    px(32, 32);  rgb("chk_32_32", 24'h000000);
    px(0, 32);   rgb("chk_0_32", 24'hFFFFFF);

    // Composite: band boundaries at VA/4 and VA/2
    i_mode = 3'd5;
    px(0, 0);
    px(128, 10);  rgb("comp_gray", 24'h444444);
    px(128, 119); rgb("comp_gray_edge", 24'h444444);
    px(128, 120); rgb("comp_bars_edge", 24'h008000);
    px(128, 239); rgb("comp_bars", 24'h008000);
    px(128, 240); rgb("comp_spec", 24'hDFFF00);

    // Solid fills
    i_mode = 3'd6;
    px(0, 0); px(5, 5); rgb("white", 24'hFFFFFF);
    i_mode = 3'd7;
    px(0, 0); px(5, 5); rgb("black", 24'h000000);

    // Moving bar, 15 px per frame
    i_mode = 3'd4; i_anim_en = 1'b1; i_step = 4'd15;
    px(0, 0);    rgb("bar_fs_px", 24'h000000);
    px(14, 1);   rgb("bar15_14", 24'h000000);
    px(15, 1);   rgb("bar15_15", 24'hFFFFFF);
    px(46, 1);   rgb("bar15_46", 24'hFFFFFF);
    px(47, 1);   rgb("bar15_47", 24'h000000);
    for (int f = 2; f <= 42; f++) px(0, 0);   // hoff = 630
    px(629, 1);  rgb("bar630_629", 24'h000000);
    px(630, 1);  rgb("bar630_630", 24'hFFFFFF);
    px(639, 1);  rgb("bar630_639", 24'hFFFFFF);
    px(0, 1);    rgb("bar630_0", 24'hFFFFFF);
    px(21, 1);   rgb("bar630_21", 24'hFFFFFF);
    px(22, 1);   rgb("bar630_22", 24'h000000);
    px(0, 0);                                  // 645 wraps to 5
    px(4, 1);    rgb("bar5_4", 24'h000000);
    px(5, 1);    rgb("bar5_5", 24'hFFFFFF);
    px(36, 1);   rgb("bar5_36", 24'hFFFFFF);
    px(37, 1);   rgb("bar5_37", 24'h000000);

    // Mid-frame changes are ignored
    i_mode = 3'd7; i_step = 4'd3;
    px(5, 2);    rgb("midframe_mode", 24'hFFFFFF); check("midframe_omode", o_mode, 4);

    // Animation off holds, step 0 is static
    i_mode = 3'd4; i_anim_en = 1'b0;
    px(0, 0); px(5, 1); rgb("hold_5", 24'hFFFFFF); px(4, 1); rgb("hold_4", 24'h000000);
    i_anim_en = 1'b1; i_step = 4'd0;
    px(0, 0); px(5, 1); rgb("step0_5", 24'hFFFFFF); px(4, 1); rgb("step0_4", 24'h000000);

    // Async reset mid-line
    px(10, 1);   check("pre_rst_de", o_de, 1); rgb("pre_rst_rgb", 24'hFFFFFF);
    #2 rst = 1'b1;
    #1;
    rgb("async_rst_rgb", 24'h000000);
    check("async_rst_de", o_de, 0);
    check("async_rst_mode", o_mode, 0);
    @(negedge clk);
    rst = 1'b0;
    px(30, 1);   rgb("post_rst_gray", 24'h000000); check("post_rst_mode", o_mode, 0);
    px(35, 1);   rgb("post_rst_gray35", 24'h111111);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
